mem_ctrl: RTL and testbench

- Sequences instruction-fetch and load/store requests from the core onto the single-ported synchronous `ram` block.
- Arbitrates the two requesters with fixed priority and translates each request into the `ram` command encoding (`rw`, `enable`, `addr`, `din`).
- Returns fetched words and load data through valid/ready handshakes.
- Sits directly upstream of `ram`; all `ram` inputs come from this block's registers.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/mem_ctrl_if.sv | 49 ++++
 rtl/mem_ctrl_arb.sv | 19 +
 rtl/mem_ctrl.sv | 144 ++++++++++++++
 tb/tb_mem_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: definitions shared by the memory controller sources.
//   - ram command encodings driven on ram_rw
//   - controller FSM state type
//   - grant owner type
//   - helper that maps a load/store request onto a ram command
package mem_pkg;

  localparam logic [1:0] RW_FETCH = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CMD  = 2'b01,
    RESP = 2'b10
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  function automatic logic [1:0] data_rw(input logic we);
    return we ? RW_WRITE : RW_READ;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: bundle of the core-side request/response handshakes and the
// ram command/data bus seen by mem_ctrl.
//   core fetch : if_req, if_addr -> if_ready, if_valid, if_data, if_err
//   core data  : d_req, d_we, d_addr, d_wdata -> d_ready, d_valid, d_rdata, d_err
//   ram        : ram_addr, ram_rw, ram_din, ram_en -> ram ; ram_fetch, ram_dout <- ram
// Modports:
//   slave  : the controller's view
//   master : the environment's view (core requesters plus the ram)
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic              if_valid;
  logic [31:0]       if_data;
  logic              if_err;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_ready;
  logic              d_valid;
  logic [31:0]       d_rdata;
  logic              d_err;

  logic [ADDR_W-1:0] ram_addr;
  logic [1:0]        ram_rw;
  logic [31:0]       ram_din;
  logic              ram_en;
  logic [31:0]       ram_fetch;
  logic [31:0]       ram_dout;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_fetch, ram_dout,
    output if_ready, if_valid, if_data, if_err,
    output d_ready, d_valid, d_rdata, d_err,
    output ram_addr, ram_rw, ram_din, ram_en
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_fetch, ram_dout,
    input  if_ready, if_valid, if_data, if_err,
    input  d_ready, d_valid, d_rdata, d_err,
    input  ram_addr, ram_rw, ram_din, ram_en
  );

endinterface

// File: rtl/mem_ctrl_arb.sv
// mem_ctrl_arb: combinational fixed-priority grant between the fetch and
// load/store requesters. Grants are only offered while the controller idles.
//   if_req, d_req : requests from the core
//   idle          : controller is in its IDLE state
//   if_ready      : fetch accepted this cycle
//   d_ready       : load/store accepted this cycle
module mem_ctrl_arb (
  input  logic if_req,
  input  logic d_req,
  input  logic idle,
  output logic if_ready,
  output logic d_ready
);

  // Data side always wins; fetch only gets through when data is quiet.
  assign d_ready  = idle & d_req;
  assign if_ready = idle & if_req & ~d_req;

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: sequences instruction-fetch and load/store requests onto a
// single-ported synchronous ram. Each transaction takes IDLE -> CMD -> RESP:
// the command is registered on accept, the ram samples it during CMD, and
// the owner's valid pulses in RESP with data taken straight from the ram's
// output registers.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mem_ctrl_if.slave (core handshakes and ram command bus)
// Configuration macro:
//   MEM_CTRL_RANGE_CHECK_EN : when defined, addresses with any bit set at or
//   above RAM_AW are never issued to the ram; the response still arrives with
//   the matching error flag set and zero data. When undefined, addresses pass
//   through unchecked and both error flags are tied low.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RAM_AW = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_ctrl_if.slave    bus
);

  state_t            state;
  owner_t            owner;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [1:0]        ram_rw_q;
  logic [31:0]       ram_din_q;
  logic              ram_en_q;
  logic              if_valid_q;
  logic              d_valid_q;
  logic              if_grant;
  logic              d_grant;
  logic              if_addr_bad;
  logic              d_addr_bad;
  logic              resp_ok;

  mem_ctrl_arb u_arb (
    .if_req   (bus.if_req),
    .d_req    (bus.d_req),
    .idle     (state == IDLE),
    .if_ready (if_grant),
    .d_ready  (d_grant)
  );

`ifdef MEM_CTRL_RANGE_CHECK_EN
  logic err_q;

  assign if_addr_bad = (bus.if_addr >> RAM_AW) != '0;
  assign d_addr_bad  = (bus.d_addr  >> RAM_AW) != '0;
  assign resp_ok     = ~err_q;
  assign bus.if_err  = if_valid_q & err_q;
  assign bus.d_err   = d_valid_q & err_q;

  // Error flag belongs to the accepted command and is held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (d_grant) begin
      err_q <= d_addr_bad;
    end else if (if_grant) begin
      err_q <= if_addr_bad;
    end
  end
`else
  assign if_addr_bad = 1'b0;
  assign d_addr_bad  = 1'b0;
  assign resp_ok     = 1'b1;
  assign bus.if_err  = 1'b0;
  assign bus.d_err   = 1'b0;
`endif

  // Controller FSM. The ram enable is raised on accept so that it is high
  // for exactly the CMD cycle; an out-of-range command simply never raises
  // it, which also drops stores. Valids are raised leaving CMD so they cover
  // only the RESP cycle, and an asynchronous reset clears them at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      ram_addr_q <= '0;
      ram_rw_q   <= RW_FETCH;
      ram_din_q  <= '0;
      ram_en_q   <= 1'b0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (d_grant) begin
            owner      <= OWN_D;
            ram_addr_q <= bus.d_addr;
            ram_rw_q   <= data_rw(bus.d_we);
            if (bus.d_we) begin
              ram_din_q <= bus.d_wdata;
            end
            ram_en_q   <= ~d_addr_bad;
            state      <= CMD;
          end else if (if_grant) begin
            owner      <= OWN_IF;
            ram_addr_q <= bus.if_addr;
            ram_rw_q   <= RW_FETCH;
            ram_en_q   <= ~if_addr_bad;
            state      <= CMD;
          end
        end
        CMD: begin
          ram_en_q <= 1'b0;
          if (owner == OWN_D) begin
            d_valid_q <= 1'b1;
          end else begin
            if_valid_q <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          if_valid_q <= 1'b0;
          d_valid_q  <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.if_ready = if_grant;
  assign bus.d_ready  = d_grant;
  assign bus.if_valid = if_valid_q;
  assign bus.d_valid  = d_valid_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_rw   = ram_rw_q;
  assign bus.ram_din  = ram_din_q;
  assign bus.ram_en   = ram_en_q;

  // Response data is forwarded from the ram's output registers during RESP
  // and forced to zero otherwise, for stores, and for rejected addresses.
  assign bus.if_data = (if_valid_q && resp_ok) ? bus.ram_fetch : 32'h0;
  assign bus.d_rdata = (d_valid_q && resp_ok && ram_rw_q == RW_READ) ? bus.ram_dout : 32'h0;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: self-checking bench for mem_ctrl with a behavioural ram model.
// Stimulus tasks push the expected response into a scoreboard queue on each
// accept; a monitor pops and compares whenever a valid pulse is presented.
module tb_mem_ctrl;
  import mem_pkg::*;

  typedef struct packed {
    logic        is_if;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  logic [31:0] mem [0:255];
  bit preloaded = 1'b0;
  logic [31:0] b2b_addr [4] = '{32'h40, 32'h41, 32'h42, 32'h43};
  logic [31:0] b2b_data [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

  always #5 clk = ~clk;

  mem_ctrl_if bus ();

  mem_ctrl #(
    .ADDR_W (32),
    .RAM_AW (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-ported ram: registered fetch/read ports, write on enable.
  // Only the low 8 address bits select a word, so high addresses alias.
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[8'h10] = 32'hE3A00001;
      mem[8'h30] = 32'h30303030;
      for (int i = 0; i < 4; i++) mem[b2b_addr[i][7:0]] = b2b_data[i];
      preloaded = 1'b1;
    end
    if (bus.ram_en) begin
      case (bus.ram_rw)
        2'b00:   bus.ram_fetch <= mem[bus.ram_addr[7:0]];
        2'b01:   bus.ram_dout  <= mem[bus.ram_addr[7:0]];
        2'b10:   mem[bus.ram_addr[7:0]] = bus.ram_din;
        default: ;
      endcase
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compares each response pulse against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && (bus.if_valid || bus.d_valid)) begin
      exp_t e;
      check_output("valid_overlap", {31'b0, bus.if_valid & bus.d_valid}, 32'h0);
      check_output("ram_en_in_resp", {31'b0, bus.ram_en}, 32'h0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_valid: got if_valid=%b d_valid=%b, expected none", bus.if_valid, bus.d_valid);
      end else begin
        e = exp_q.pop_front();
        check_output("resp_owner", {31'b0, bus.if_valid}, {31'b0, e.is_if});
        if (e.is_if) begin
          check_output("if_data", bus.if_data, e.data);
          check_output("if_err", {31'b0, bus.if_err}, {31'b0, e.err});
        end else begin
          check_output("d_rdata", bus.d_rdata, e.data);
          check_output("d_err", {31'b0, bus.d_err}, {31'b0, e.err});
        end
      end
    end
  end

  // One full transaction, called and returning at a falling edge in IDLE.
  task automatic apply_stimulus(input bit is_d, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_data,
                                input bit exp_err);
    bit got = 1'b0;
    if (is_d) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    for (int n = 0; n < 20; n++) begin
      #1;
      if (is_d ? bus.d_ready : bus.if_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout: got no ready, expected accept of addr %h", addr);
      bus.d_req = 1'b0; bus.if_req = 1'b0;
      return;
    end
    exp_q.push_back('{is_if: !is_d, data: exp_data, err: exp_err});
    @(posedge clk);
    @(negedge clk);
    bus.d_req = 1'b0;
    bus.if_req = 1'b0;
    check_output("cmd_ram_en", {31'b0, bus.ram_en}, {31'b0, !exp_err});
    check_output("cmd_ram_rw", {30'b0, bus.ram_rw}, {30'b0, is_d ? (we ? RW_WRITE : RW_READ) : RW_FETCH});
    check_output("cmd_ram_addr", bus.ram_addr, addr);
    if (is_d && we) check_output("cmd_ram_din", bus.ram_din, wdata);
    #1;
    check_output("ready_in_cmd", {30'b0, bus.if_ready, bus.d_ready}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_ram_en"}, {31'b0, bus.ram_en}, 32'h0);
    check_output({tag, "_ram_rw"}, {30'b0, bus.ram_rw}, 32'h0);
    check_output({tag, "_ram_addr"}, bus.ram_addr, 32'h0);
    check_output({tag, "_ram_din"}, bus.ram_din, 32'h0);
    check_output({tag, "_valids"}, {30'b0, bus.if_valid, bus.d_valid}, 32'h0);
    check_output({tag, "_errs"}, {30'b0, bus.if_err, bus.d_err}, 32'h0);
    check_output({tag, "_if_data"}, bus.if_data, 32'h0);
    check_output({tag, "_d_rdata"}, bus.d_rdata, 32'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int unsigned last_cyc;
    bit got;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] fetch, store, load");
    apply_stimulus(1'b0, 1'b0, 32'h10, 32'h0, 32'hE3A00001, 1'b0);
    apply_stimulus(1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0);

    $display("[TB] contention");
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20;
    #1;
    check_output("contend_ready", {30'b0, bus.if_ready, bus.d_ready}, 32'h1);
    exp_q.push_back('{is_if: 1'b0, data: 32'hDEADBEEF, err: 1'b0});
    @(posedge clk);
    @(negedge clk);
    bus.d_req = 1'b0;
    k = 1;
    got = 1'b0;
    for (int n = 0; n < 10; n++) begin
      #1;
      if (bus.if_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      k++;
    end
    check_output("contend_if_delay", k, 3);
    if (got) exp_q.push_back('{is_if: 1'b1, data: 32'hE3A00001, err: 1'b0});
    @(posedge clk);
    @(negedge clk);
    bus.if_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] back-to-back fetches");
    bus.if_req = 1'b1;
    bus.if_addr = b2b_addr[0];
    last_cyc = 0;
    for (int i = 0; i < 4; i++) begin
      got = 1'b0;
      for (int n = 0; n < 10; n++) begin
        #1;
        if (bus.if_ready) begin
          got = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (!got) begin
        checks++;
        errors++;
        $display("[TB] FAIL b2b_timeout: got no if_ready, expected accept %0d", i);
      end else begin
        exp_q.push_back('{is_if: 1'b1, data: b2b_data[i], err: 1'b0});
        if (i > 0) check_output("b2b_spacing", cyc - last_cyc, 3);
        last_cyc = cyc;
      end
      @(posedge clk);
      @(negedge clk);
      if (i == 3) bus.if_req = 1'b0;
      else bus.if_addr = b2b_addr[i+1];
    end
    repeat (2) @(negedge clk);

    $display("[TB] reset during CMD of a store");
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h30; bus.d_wdata = 32'hCAFEF00D;
    #1;
    check_output("abort_accept", {31'b0, bus.d_ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    bus.d_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    apply_stimulus(1'b1, 1'b0, 32'h30, 32'h0, 32'h30303030, 1'b0);

    $display("[TB] reset during RESP");
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    #1;
    check_output("resp_rst_accept", {31'b0, bus.if_ready}, 32'h1);
    exp_q.push_back('{is_if: 1'b1, data: 32'hE3A00001, err: 1'b0});
    @(posedge clk);
    @(negedge clk);
    bus.if_req = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("resp_rst_valid", {30'b0, bus.if_valid, bus.d_valid}, 32'h0);
    check_output("resp_rst_data", bus.if_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] high address load");
`ifdef MEM_CTRL_RANGE_CHECK_EN
    apply_stimulus(1'b1, 1'b0, 32'h0001_0000, 32'h0, 32'h0, 1'b1);
    apply_stimulus(1'b1, 1'b1, 32'h0001_0020, 32'h12345678, 32'h0, 1'b1);
    apply_stimulus(1'b1, 1'b0, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0);
`else
    apply_stimulus(1'b1, 1'b0, 32'hFFFF_0010, 32'h0, 32'hE3A00001, 1'b0);
`endif

    repeat (3) @(negedge clk);
    check_output("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
